// File: rtl/std_sq_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : std_sq_wb_buffer
// Purpose  : In-order write-back buffer between the store-data execution
//            unit and the store-queue data write port. Captures each
//            store-data result, formats the data to store width at enqueue,
//            absorbs store-queue backpressure, raises an early stall toward
//            issue and discards entries squashed by a redirect.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH  buffer entries (power of two, >= 2)
//   ROB_W  robIdx value width
//   SQ_W   sqIdx value width
// Ports
//   clock / reset               clock, asynchronous active-low reset
//   io_in_*                     store-data result (no ready on this side)
//   io_redirect_*               pipeline flush request
//   io_out_valid/ready          store-queue data write handshake
//   io_out_sqIdx_*, io_out_data target entry and size-replicated data
//   io_stall                    registered stall toward issue
//   io_overflow                 sticky drop-on-full error flag
// Optional build macro
//   STD_SQ_WB_PERF_EN  adds io_perf_wr_cnt / io_perf_kill_cnt (32-bit,
//                      saturating) counting writes and redirect kills.
// ============================================================================
module std_sq_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int SQ_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  input  logic [6:0]       io_in_fuOpType,
  input  logic             io_in_robIdx_flag,
  input  logic [ROB_W-1:0] io_in_robIdx_value,
  input  logic             io_in_sqIdx_flag,
  input  logic [SQ_W-1:0]  io_in_sqIdx_value,
  input  logic [63:0]      io_in_data,
  input  logic             io_redirect_valid,
  input  logic             io_redirect_robIdx_flag,
  input  logic [ROB_W-1:0] io_redirect_robIdx_value,
  input  logic             io_redirect_level,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_out_sqIdx_flag,
  output logic [SQ_W-1:0]  io_out_sqIdx_value,
  output logic [63:0]      io_out_data,
  output logic             io_stall,
  output logic             io_overflow
`ifdef STD_SQ_WB_PERF_EN
  ,
  output logic [31:0]      io_perf_wr_cnt,
  output logic [31:0]      io_perf_kill_cnt
`endif
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_ptr_w = c_idx_w + 1;

  // a is younger than b in ROB order (wrap flag disambiguates the wrap)
  function automatic logic f_is_after(input logic af, input logic [ROB_W-1:0] av,
                                      input logic bf, input logic [ROB_W-1:0] bv);
    return (af ^ bf) ^ (av > bv);
  endfunction

  function automatic logic f_killed(input logic ef, input logic [ROB_W-1:0] ev,
                                    input logic rvld, input logic rf,
                                    input logic [ROB_W-1:0] rv, input logic lvl);
    return rvld & (f_is_after(ef, ev, rf, rv) | (lvl & (ef == rf) & (ev == rv)));
  endfunction

  // Storage
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [DEPTH-1:0]   r_live;
  logic [DEPTH-1:0]   r_rob_flag;
  logic [ROB_W-1:0]   r_rob_val [DEPTH];
  logic [DEPTH-1:0]   r_sq_flag;
  logic [SQ_W-1:0]    r_sq_val  [DEPTH];
  logic [63:0]        r_data    [DEPTH];
  logic               r_stall;
  logic               r_ovf;

  logic [c_idx_w-1:0] w_head_idx;
  logic [c_idx_w-1:0] w_tail_idx;
  logic [c_ptr_w-1:0] w_count;
  logic [c_ptr_w-1:0] w_count_nxt;
  logic               w_empty;
  logic               w_full;
  logic [DEPTH-1:0]   w_kill;
  logic [DEPTH-1:0]   w_live_nxt;
  logic               w_in_kill;
  logic               w_enq_req;
  logic               w_enq;
  logic               w_drop;
  logic               w_fire;
  logic               w_silent;
  logic               w_deq;
  logic               w_out_valid;
  logic [63:0]        w_fmt;
  logic               w_unused;

  // Only the size field of fuOpType matters to this block
  assign w_unused = ^io_in_fuOpType[6:2];

  assign w_head_idx = r_head[c_idx_w-1:0];
  assign w_tail_idx = r_tail[c_idx_w-1:0];
  assign w_count    = r_tail - r_head;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_head_idx == w_tail_idx) & (r_head[c_idx_w] != r_tail[c_idx_w]);

  // Every live entry is checked against the redirect in parallel
  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    assign w_kill[g] = r_live[g] & f_killed(r_rob_flag[g], r_rob_val[g],
                                            io_redirect_valid, io_redirect_robIdx_flag,
                                            io_redirect_robIdx_value, io_redirect_level);
  end

  assign w_in_kill = f_killed(io_in_robIdx_flag, io_in_robIdx_value,
                              io_redirect_valid, io_redirect_robIdx_flag,
                              io_redirect_robIdx_value, io_redirect_level);

  // A head entry being killed this cycle must not present a write
  assign w_out_valid = ~w_empty & r_live[w_head_idx] & ~w_kill[w_head_idx];
  assign w_fire      = w_out_valid & io_out_ready;
  // Dead head entries leave one per cycle without touching the store queue
  assign w_silent    = ~w_empty & ~r_live[w_head_idx];
  assign w_deq       = w_fire | w_silent;

  assign w_enq_req   = io_in_valid & ~w_in_kill;
  // When full, a same-cycle dequeue frees the very slot the tail points at
  assign w_enq       = w_enq_req & (~w_full | w_deq);
  assign w_drop      = w_enq_req & w_full & ~w_deq;

  assign w_count_nxt = w_count + c_ptr_w'(w_enq) - c_ptr_w'(w_deq);

  always_comb begin
    w_fmt = io_in_data;
    case (io_in_fuOpType[1:0])
      2'd0:    w_fmt = {8{io_in_data[7:0]}};
      2'd1:    w_fmt = {4{io_in_data[15:0]}};
      2'd2:    w_fmt = {2{io_in_data[31:0]}};
      default: w_fmt = io_in_data;
    endcase
  end

  // Kill and dequeue clear first; enqueue wins on the shared slot when full
  always_comb begin
    w_live_nxt = r_live & ~w_kill;
    if (w_deq) w_live_nxt[w_head_idx] = 1'b0;
    if (w_enq) w_live_nxt[w_tail_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_live     <= '0;
      r_rob_flag <= '0;
      r_sq_flag  <= '0;
      r_stall    <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rob_val[i] <= '0;
        r_sq_val[i]  <= '0;
        r_data[i]    <= '0;
      end
    end else begin
      r_live <= w_live_nxt;
      if (w_deq) r_head <= r_head + c_ptr_w'(1);
      if (w_enq) begin
        r_tail                 <= r_tail + c_ptr_w'(1);
        r_rob_flag[w_tail_idx] <= io_in_robIdx_flag;
        r_rob_val[w_tail_idx]  <= io_in_robIdx_value;
        r_sq_flag[w_tail_idx]  <= io_in_sqIdx_flag;
        r_sq_val[w_tail_idx]   <= io_in_sqIdx_value;
        r_data[w_tail_idx]     <= w_fmt;
      end
      // Leaves one slot for a uop already past issue when stall rises
      r_stall <= (w_count_nxt >= c_ptr_w'(DEPTH - 1));
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign io_out_valid       = w_out_valid;
  assign io_out_sqIdx_flag  = r_sq_flag[w_head_idx];
  assign io_out_sqIdx_value = r_sq_val[w_head_idx];
  assign io_out_data        = r_data[w_head_idx];
  assign io_stall           = r_stall;
  assign io_overflow        = r_ovf;

`ifdef STD_SQ_WB_PERF_EN
  localparam int c_kcnt_w = $clog2(DEPTH + 2);

  logic [31:0]         r_perf_wr;
  logic [31:0]         r_perf_kill;
  logic [c_kcnt_w-1:0] w_kill_num;
  logic [32:0]         w_wr_sum;
  logic [32:0]         w_kill_sum;

  always_comb begin
    w_kill_num = c_kcnt_w'(io_in_valid & w_in_kill);
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_num = w_kill_num + c_kcnt_w'(w_kill[i]);
    end
  end

  assign w_wr_sum   = {1'b0, r_perf_wr} + 33'(w_fire);
  assign w_kill_sum = {1'b0, r_perf_kill} + 33'(w_kill_num);

  // Carry out of the 32-bit sum means the counter saturates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_wr   <= '0;
      r_perf_kill <= '0;
    end else begin
      r_perf_wr   <= w_wr_sum[32]   ? 32'hFFFF_FFFF : w_wr_sum[31:0];
      r_perf_kill <= w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
    end
  end

  assign io_perf_wr_cnt   = r_perf_wr;
  assign io_perf_kill_cnt = r_perf_kill;
`endif

endmodule
`default_nettype wire

// File: tb/tb_std_sq_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_sq_wb_buffer
// Purpose  : Self-checking bench for std_sq_wb_buffer. A queue-based model
//            of the buffer is compared against the DUT every cycle, and
//            directed scenarios pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_sq_wb_buffer;

  localparam int DEPTH = 4;
  localparam int ROB_W = 5;
  localparam int SQ_W  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid;
  logic [6:0]       io_in_fuOpType;
  logic             io_in_robIdx_flag;
  logic [ROB_W-1:0] io_in_robIdx_value;
  logic             io_in_sqIdx_flag;
  logic [SQ_W-1:0]  io_in_sqIdx_value;
  logic [63:0]      io_in_data;
  logic             io_redirect_valid;
  logic             io_redirect_robIdx_flag;
  logic [ROB_W-1:0] io_redirect_robIdx_value;
  logic             io_redirect_level;
  logic             io_out_valid;
  logic             io_out_ready;
  logic             io_out_sqIdx_flag;
  logic [SQ_W-1:0]  io_out_sqIdx_value;
  logic [63:0]      io_out_data;
  logic             io_stall;
  logic             io_overflow;

  std_sq_wb_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W), .SQ_W(SQ_W)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_in_valid              (io_in_valid),
    .io_in_fuOpType           (io_in_fuOpType),
    .io_in_robIdx_flag        (io_in_robIdx_flag),
    .io_in_robIdx_value       (io_in_robIdx_value),
    .io_in_sqIdx_flag         (io_in_sqIdx_flag),
    .io_in_sqIdx_value        (io_in_sqIdx_value),
    .io_in_data               (io_in_data),
    .io_redirect_valid        (io_redirect_valid),
    .io_redirect_robIdx_flag  (io_redirect_robIdx_flag),
    .io_redirect_robIdx_value (io_redirect_robIdx_value),
    .io_redirect_level        (io_redirect_level),
    .io_out_valid             (io_out_valid),
    .io_out_ready             (io_out_ready),
    .io_out_sqIdx_flag        (io_out_sqIdx_flag),
    .io_out_sqIdx_value       (io_out_sqIdx_value),
    .io_out_data              (io_out_data),
    .io_stall                 (io_stall),
    .io_overflow              (io_overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit             rf;
    bit [ROB_W-1:0] rv;
    bit             sf;
    bit [SQ_W-1:0]  sv;
    bit [63:0]      d;
    bit             live;
  } ent_t;

  ent_t       mq[$];
  bit         m_stall;
  bit         m_ovf;
  logic [3:0] wlog[$];   // sqIdx of every completed store-queue write

  function automatic bit is_after(bit af, bit [ROB_W-1:0] av, bit bf, bit [ROB_W-1:0] bv);
    return (af ^ bf) ^ (av > bv);
  endfunction

  function automatic bit killed(bit f, bit [ROB_W-1:0] v);
    return io_redirect_valid &&
           (is_after(f, v, io_redirect_robIdx_flag, io_redirect_robIdx_value) ||
            (io_redirect_level && f == io_redirect_robIdx_flag && v == io_redirect_robIdx_value));
  endfunction

  function automatic bit [63:0] fmt(bit [1:0] sz, bit [63:0] d);
    case (sz)
      2'd0:    return 64'(d[7:0])  * 64'h0101_0101_0101_0101;
      2'd1:    return 64'(d[15:0]) * 64'h0001_0001_0001_0001;
      2'd2:    return 64'(d[31:0]) * 64'h0000_0001_0000_0001;
      default: return d;
    endcase
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      mq.delete();
      m_stall = 0;
      m_ovf   = 0;
      chk("rst_valid", 64'(io_out_valid), 0);
      chk("rst_stall", 64'(io_stall), 0);
      chk("rst_ovf",   64'(io_overflow), 0);
      chk("rst_data",  io_out_data, 0);
      chk("rst_sq",    64'({io_out_sqIdx_flag, io_out_sqIdx_value}), 0);
    end else begin
      bit   exp_v, deq, in_ok;
      int   sz0;
      ent_t e;
      exp_v = (mq.size() != 0) && mq[0].live && !killed(mq[0].rf, mq[0].rv);
      chk("m_valid", 64'(io_out_valid), 64'(exp_v));
      if (exp_v) begin
        chk("m_data", io_out_data, mq[0].d);
        chk("m_sq",   64'({io_out_sqIdx_flag, io_out_sqIdx_value}), 64'({mq[0].sf, mq[0].sv}));
      end
      chk("m_stall", 64'(io_stall), 64'(m_stall));
      chk("m_ovf",   64'(io_overflow), 64'(m_ovf));
      if (io_out_valid && io_out_ready) wlog.push_back(io_out_sqIdx_value);
      // advance the model to the state after the coming edge
      deq = (exp_v && io_out_ready) || (mq.size() != 0 && !mq[0].live);
      foreach (mq[i]) if (mq[i].live && killed(mq[i].rf, mq[i].rv)) mq[i].live = 0;
      sz0 = mq.size();
      if (deq) void'(mq.pop_front());
      in_ok = io_in_valid && !killed(io_in_robIdx_flag, io_in_robIdx_value);
      if (in_ok) begin
        if (sz0 < DEPTH || deq) begin
          e.rf = io_in_robIdx_flag; e.rv = io_in_robIdx_value;
          e.sf = io_in_sqIdx_flag;  e.sv = io_in_sqIdx_value;
          e.d  = fmt(io_in_fuOpType[1:0], io_in_data);
          e.live = 1;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
      m_stall = (mq.size() >= DEPTH - 1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // one store-data result presented for one cycle
  task automatic st(input logic [3:0] sq, input bit rf, input logic [4:0] rv,
                    input logic [1:0] sz, input logic [63:0] d);
    io_in_valid        = 1;
    io_in_sqIdx_flag   = 0;
    io_in_sqIdx_value  = sq;
    io_in_robIdx_flag  = rf;
    io_in_robIdx_value = rv;
    io_in_fuOpType     = {5'b0, sz};
    io_in_data         = d;
    step();
    io_in_valid = 0;
  endtask

  task automatic redirect(input bit rf, input logic [4:0] rv, input bit lvl);
    io_redirect_valid        = 1;
    io_redirect_robIdx_flag  = rf;
    io_redirect_robIdx_value = rv;
    io_redirect_level        = lvl;
    step();
    io_redirect_valid = 0;
  endtask

  // seq holds expected sqIdx values, first write in seq[3:0]
  task automatic check_log(input string name, input int len, input logic [31:0] seq);
    chk({name, "_len"}, 64'(wlog.size()), 64'(len));
    for (int i = 0; i < len && i < wlog.size(); i++)
      chk({name, "_ord"}, 64'(wlog[i]), 64'((seq >> (4 * i)) & 32'hF));
    wlog.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; io_in_valid = 0; io_in_fuOpType = 0; io_in_robIdx_flag = 0;
    io_in_robIdx_value = 0; io_in_sqIdx_flag = 0; io_in_sqIdx_value = 0;
    io_in_data = 0; io_redirect_valid = 0; io_redirect_robIdx_flag = 0;
    io_redirect_robIdx_value = 0; io_redirect_level = 0; io_out_ready = 0;
    #1;
    chk("reset_valid", 64'(io_out_valid), 0);
    chk("reset_data", io_out_data, 0);
    step(); step();
    reset = 1;
    step();

    // single byte store, latency 1
    io_out_ready = 1;
    st(4'd3, 0, 5'd0, 2'd0, 64'h1234_5678_9ABC_DEA5);
    chk("single_valid", 64'(io_out_valid), 1);
    chk("single_sq", 64'(io_out_sqIdx_value), 3);
    chk("single_data", io_out_data, 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    chk("single_empty", 64'(io_out_valid), 0);
    check_log("single", 1, 32'h3);

    // backpressure, stall and overflow
    io_out_ready = 0;
    st(4'd0, 0, 5'd1, 2'd2, 64'h1111_2222_3333_4440);
    chk("bp_stall1", 64'(io_stall), 0);
    st(4'd1, 0, 5'd2, 2'd2, 64'h1111_2222_3333_4441);
    chk("bp_stall2", 64'(io_stall), 0);
    st(4'd2, 0, 5'd3, 2'd2, 64'h1111_2222_3333_4442);
    chk("bp_stall3", 64'(io_stall), 1);
    st(4'd3, 0, 5'd4, 2'd2, 64'h1111_2222_3333_4443);
    chk("bp_ovf4", 64'(io_overflow), 0);
    st(4'd15, 0, 5'd5, 2'd2, 64'h1111_2222_3333_4444);
    chk("bp_ovf5", 64'(io_overflow), 1);
    io_out_ready = 1;
    chk("bp_head_data", io_out_data, 64'h3333_4440_3333_4440);
    repeat (4) step();
    chk("bp_drained", 64'(io_out_valid), 0);
    check_log("bp", 4, 32'h3210);

    // redirect, level 0 keeps robIdx 6, level 1 drops it
    io_out_ready = 0;
    st(4'd4, 0, 5'd4, 2'd3, 64'h0);
    st(4'd5, 0, 5'd6, 2'd3, 64'h6);
    st(4'd6, 0, 5'd9, 2'd3, 64'h9);
    redirect(0, 5'd6, 0);
    io_out_ready = 1;
    repeat (5) step();
    check_log("redir_l0", 2, 32'h54);
    io_out_ready = 0;
    st(4'd4, 0, 5'd4, 2'd3, 64'h0);
    st(4'd5, 0, 5'd6, 2'd3, 64'h6);
    st(4'd6, 0, 5'd9, 2'd3, 64'h9);
    redirect(0, 5'd6, 1);
    io_out_ready = 1;
    repeat (5) step();
    check_log("redir_l1", 1, 32'h4);

    // redirect across the ROB wrap
    io_out_ready = 0;
    st(4'd7, 1, 5'd2, 2'd1, 64'hBEEF);
    redirect(0, 5'd30, 0);
    io_out_ready = 1;
    repeat (3) step();
    check_log("wrap_kill", 0, 32'h0);
    io_out_ready = 0;
    st(4'd7, 1, 5'd2, 2'd1, 64'hBEEF);
    redirect(1, 5'd5, 0);
    io_out_ready = 1;
    repeat (3) step();
    check_log("wrap_keep", 1, 32'h7);

    // asynchronous reset while a write is held off
    io_out_ready = 0;
    st(4'd1, 0, 5'd1, 2'd3, 64'hDEAD_0000_0000_0001);
    chk("ar_pre_valid", 64'(io_out_valid), 1);
    #2 reset = 0;
    #1;
    chk("ar_valid", 64'(io_out_valid), 0);
    chk("ar_ovf", 64'(io_overflow), 0);
    chk("ar_data", io_out_data, 0);
    chk("ar_sq", 64'(io_out_sqIdx_value), 0);
    step(); step();
    reset = 1;
    io_out_ready = 1;
    st(4'd2, 0, 5'd2, 2'd1, 64'h0000_0000_1234_BEEF);
    chk("ar_post_valid", 64'(io_out_valid), 1);
    chk("ar_post_data", io_out_data, 64'hBEEF_BEEF_BEEF_BEEF);
    step();
    check_log("ar", 1, 32'h2);

    // full with simultaneous enqueue and dequeue
    io_out_ready = 0;
    st(4'd8,  0, 5'd8,  2'd3, 64'h8);
    st(4'd9,  0, 5'd9,  2'd3, 64'h9);
    st(4'd10, 0, 5'd10, 2'd3, 64'hA);
    st(4'd11, 0, 5'd11, 2'd3, 64'hB);
    io_out_ready = 1;
    st(4'd12, 0, 5'd12, 2'd3, 64'hC);
    io_out_ready = 0;
    chk("fs_ovf", 64'(io_overflow), 0);
    chk("fs_stall", 64'(io_stall), 1);
    chk("fs_head", 64'(io_out_sqIdx_value), 9);
    io_out_ready = 1;
    repeat (5) step();
    chk("fs_ovf_end", 64'(io_overflow), 0);
    check_log("fs", 5, 32'hCBA98);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/std_sq_wb_buffer.md
Name: std_sq_wb_buffer

Overview:
- Sits directly downstream of the store-data execution unit.
- Captures each store-data result (uop robIdx/sqIdx/fuOpType plus 64-bit data) into a small in-order buffer.
- Formats the data to store width and drives it into the store-queue data write port with a valid/ready handshake.
- The execution unit has no ready input, so this block absorbs store-queue backpressure, asserts an early stall toward issue, and discards entries squashed by a redirect.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- ROB_W, 5, robIdx value width.
- SQ_W, 4, sqIdx value width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  store-data result valid; no ready exists on this side.
- io_in_fuOpType  in  7  bits [1:0] give the store size: 0=byte, 1=half, 2=word, 3=double.
- io_in_robIdx_flag  in  1  ROB index wrap flag.
- io_in_robIdx_value  in  ROB_W  ROB index.
- io_in_sqIdx_flag  in  1  store-queue index wrap flag.
- io_in_sqIdx_value  in  SQ_W  store-queue index.
- io_in_data  in  64  raw store data.
- io_redirect_valid  in  1  pipeline flush request.
- io_redirect_robIdx_flag  in  1  redirect ROB flag.
- io_redirect_robIdx_value  in  ROB_W  redirect ROB index.
- io_redirect_level  in  1  1 = also flush the redirecting uop itself.
- io_out_valid  out  1  store-queue write request.
- io_out_ready  in  1  store queue accepts the write.
- io_out_sqIdx_flag  out  1  target store-queue entry flag.
- io_out_sqIdx_value  out  SQ_W  target store-queue entry.
- io_out_data  out  64  size-replicated store data.
- io_stall  out  1  tells the issue stage to stop issuing store-data uops.
- io_overflow  out  1  sticky error flag.

Behaviour:
- Storage is a circular buffer:
  - head/tail pointers, each with an extra wrap bit;
  - a per-entry live bit;
  - count = tail - head.
- Enqueue:
  - when io_in_valid and the incoming uop is not killed by a same-cycle redirect, write at tail and set live.
  - Enqueue is registered: earliest io_out_valid is the cycle after io_in_valid (latency 1).
- Output: io_out_valid = (count != 0) & live[head]. io_out_* come combinationally from the head entry.
- Dequeue: head advances when io_out_valid & io_out_ready, or when count != 0 & !live[head] (silent pop of a killed entry, at most one per cycle).
- Kill rule, with isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value):
  - an entry e is killed when io_redirect_valid & (isAfter(e, redirect) | (io_redirect_level & e == redirect));
  - all live entries and the incoming uop are evaluated in the same cycle;
  - killed entries clear live immediately;
  - a head entry killed in that same cycle must not raise io_out_valid.
- Data formatting by fuOpType[1:0]:
  - byte: data[7:0] replicated ×8;
  - half: data[15:0] replicated ×4;
  - word: data[31:0] replicated ×2;
  - double: passthrough.
  - Formatting is applied at enqueue; the stored data is already formatted.
- io_stall is registered: it equals 1 when the next-state count is ≥ DEPTH-1. This guarantees one free slot for a uop already in flight.
- Full handling:
  - enqueue while count == DEPTH with no dequeue in the same cycle: the input is dropped and io_overflow sets and stays set until reset;
  - enqueue and dequeue in the same cycle while full: accepted, count unchanged.
- Empty handling: io_out_valid = 0; a redirect has no effect.
- Pointer wrap: pointers wrap modulo DEPTH and the wrap bit toggles. Full = pointer values equal with wrap bits different.
- Reset (asynchronous, any time, including mid-transfer):
  - head = tail = 0; all live bits = 0;
  - io_out_valid = 0, io_stall = 0, io_overflow = 0;
  - io_out_data, io_out_sqIdx_* = 0;
  - an in-progress handshake is abandoned.

Optional Feature:
- STD_SQ_WB_PERF_EN defined adds two outputs:
  - io_perf_wr_cnt, 32 bits: counts io_out_valid & io_out_ready;
  - io_perf_kill_cnt, 32 bits: counts entries plus incoming uops killed by redirect.
  - Both saturate at all-ones and reset to 0.
- STD_SQ_WB_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single store: enqueue sqIdx=3, fuOpType=0, data=0x...A5, out_ready=1.
  - Next cycle: io_out_valid=1, sqIdx=3, data=0xA5A5A5A5A5A5A5A5.
  - Buffer empty one cycle later.
- Backpressure and overflow: out_ready=0, four consecutive word stores.
  - io_stall=1 after the third; the fourth is accepted; a fifth input sets io_overflow=1.
  - Releasing ready drains the four entries in order with data[31:0] replicated.
- Redirect: buffer holds robIdx values 4, 6, 9 (flag 0); redirect robIdx=6, level=0.
  - Entry 9 is discarded; entries 4 and 6 are written. With level=1, only 4 is written.
- Redirect wrap-around: entry robIdx flag=1 value=2; redirect flag=0 value=30, level=0.
  - The entry is killed (younger across the wrap).
  - The same entry against redirect flag=1 value=5 survives.
- Full with simultaneous enqueue and dequeue: DEPTH entries present, out_ready=1 and io_in_valid in the same cycle.
  - No overflow, count stays DEPTH, ordering preserved.
- Reset asserted while io_out_valid=1 and out_ready=0: all outputs 0 asynchronously.
  - After release, a new store appears with latency 1.
